seg_scan_driver: RTL



---
 rtl/seg_pkg.sv | 45 ++++
 rtl/seg_hex_decoder.sv | 18 +
 rtl/seg_scan_driver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, types and the hex-to-7-segment map used by
// the 8-digit scan driver.
package seg_pkg;

  localparam int SEG_DIGITS = 8;

  // Cathode bit positions within the 8-bit cathode vector
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Eight hex nibbles in [31:0], eight decimal points in [39:32]
  typedef logic [39:0] seg_word_t;

  // Active-high segment pattern, bit order gfedcba
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: one digit (nibble + decimal point) to the active-low
// cathode vector of a common-anode display.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] ca
);

  // Invert the active-high pattern because cathodes sink current when low
  always_comb begin
    ca                = 8'hFF;
    ca[SEG_G:SEG_A]   = ~hex7(nibble);
    ca[SEG_DP]        = ~dp;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed drive for an 8-digit common-anode
// 7-segment display with frame snapshotting, a blank gap at the start of
// every slot and 8-level brightness PWM.
// Optional build macro SEG_LZ_BLANK_EN enables leading-zero blanking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int P_CLK_HZ  = 50_000_000,
  parameter int P_SCAN_HZ = 1000,
  parameter int P_DIGITS  = 8,
  parameter int P_GAP     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] seg_data_i,
  input  logic [2:0]  bright_i,
  output logic [7:0]  seg_an_o,
  output logic [7:0]  seg_ca_o,
  output logic        frame_o
);

  localparam int DIV = P_CLK_HZ / P_SCAN_HZ;
  localparam int TW  = $clog2(DIV + 1);

  generate
    if (DIV < 16) begin : g_bad_div
      $error("seg_scan_driver: DIV must be at least 16");
    end
    if (P_DIGITS != SEG_DIGITS) begin : g_bad_digits
      $error("seg_scan_driver: only 8 digits are supported");
    end
    if ((P_GAP < 2) || (P_GAP >= DIV / 8)) begin : g_bad_gap
      $error("seg_scan_driver: P_GAP must satisfy 2 <= P_GAP < DIV/8");
    end
  endgenerate

  logic [TW-1:0] cnt_r;
  logic [TW-1:0] thresh_r;
  logic [2:0]    idx_r;
  logic [2:0]    bright_q_r;
  seg_word_t     snapshot_r;

  logic          load_s;
  logic          cnt_wrap_s;
  logic [2:0]    bright_src_s;
  logic [TW-1:0] thresh_next_s;
  logic          active_s;
  logic [3:0]    nibble_s;
  logic [7:0]    dp_vec_s;
  logic          digit_blank_s;
  logic [7:0]    dec_ca_s;

  // Slot timing, frame load strobe and the PWM threshold for this frame
  always_comb begin
    load_s        = (cnt_r == {TW{1'b0}}) && (idx_r == 3'd0);
    cnt_wrap_s    = (cnt_r == TW'(DIV - 1));
    // The threshold is computed in the same cycle bright_q is loaded, so
    // take the incoming brightness at a load event.
    bright_src_s  = load_s ? bright_i : bright_q_r;
    thresh_next_s = TW'(((32'({1'b0, bright_src_s}) + 32'd1) * 32'(DIV)) >> 3);
    active_s      = (cnt_r >= TW'(P_GAP)) && (cnt_r < thresh_r);
    nibble_s      = snapshot_r[{idx_r, 2'b00} +: 4];
    dp_vec_s      = snapshot_r[39:32];
  end

`ifdef SEG_LZ_BLANK_EN
  logic [7:0] blank_vec_s;
  logic       lz_run_s;

  // Blank a digit when it and every digit to its left are zero with no dp
  always_comb begin
    blank_vec_s = 8'h00;
    lz_run_s    = 1'b1;
    for (int j = 7; j >= 1; j--) begin
      lz_run_s       = lz_run_s && (snapshot_r[4*j +: 4] == 4'h0) && !dp_vec_s[j];
      blank_vec_s[j] = lz_run_s;
    end
    digit_blank_s = blank_vec_s[idx_r];
  end
`else
  assign digit_blank_s = 1'b0;
`endif

  seg_hex_decoder u_dec (
    .nibble (nibble_s),
    .dp     (dp_vec_s[idx_r]),
    .ca     (dec_ca_s)
  );

  // Slot counter, digit index, frame snapshot and PWM threshold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {TW{1'b0}};
      idx_r      <= 3'd0;
      snapshot_r <= 40'h00_0000_0000;
      bright_q_r <= 3'd0;
      thresh_r   <= {TW{1'b0}};
    end else begin
      if (cnt_wrap_s) begin
        cnt_r <= {TW{1'b0}};
        idx_r <= idx_r + 3'd1;
      end else begin
        cnt_r <= cnt_r + TW'(1);
      end
      if (load_s) begin
        snapshot_r <= seg_data_i;
        bright_q_r <= bright_i;
      end
      if (cnt_r == {TW{1'b0}}) begin
        thresh_r <= thresh_next_s;
      end
    end
  end

  // Registered display drive; the gap at slot start keeps anodes exclusive
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_an_o <= 8'hFF;
      seg_ca_o <= 8'hFF;
      frame_o  <= 1'b0;
    end else begin
      if (active_s && !digit_blank_s) begin
        seg_an_o <= ~(8'd1 << idx_r);
        seg_ca_o <= dec_ca_s;
      end else begin
        seg_an_o <= 8'hFF;
        seg_ca_o <= 8'hFF;
      end
      frame_o <= load_s;
    end
  end

endmodule
